// File: rtl/btn_set_ctrl.sv
// ---------------------------------------------------------------------------
// btn_set_ctrl
//
// Edit controller for a two-field settable value such as hours:minutes.
// It takes three single-cycle button pulse streams (MODE, INC, DEC) and
// latches each one in its own pending flag. Each cycle it services at most
// one pending event, with MODE highest priority, then INC, then DEC.
//
// The edit FSM steps IDLE -> SET_HI -> SET_LO -> DONE -> IDLE:
//   * Entering SET_HI snapshots the current hi/lo values.
//   * DONE raises commit for one cycle and then returns to IDLE.
//   * If an edit state sees no serviced event for TIMEOUT cycles, the FSM
//     restores the snapshot and raises abort.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   mode_pulse  in   1  advance edit field / enter edit / commit
//   inc_pulse   in   1  increment selected field (wraps at max)
//   dec_pulse   in   1  decrement selected field (wraps at 0)
//   hi_val      out  W  high field value (working value while editing)
//   lo_val      out  W  low field value (working value while editing)
//   sel_hi      out  1  high field selected for editing
//   sel_lo      out  1  low field selected for editing
//   editing     out  1  FSM in SET_HI or SET_LO
//   commit      out  1  one-cycle pulse, new value accepted
//   abort       out  1  one-cycle pulse, edit timed out and values reverted
//   drop        out  1  one-cycle pulse, an input pulse was discarded
// ---------------------------------------------------------------------------
module btn_set_ctrl #(
  parameter int W       = 6,
  parameter int HI_MAX  = 23,
  parameter int LO_MAX  = 59,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode_pulse,
  input  logic         inc_pulse,
  input  logic         dec_pulse,
  output logic [W-1:0] hi_val,
  output logic [W-1:0] lo_val,
  output logic         sel_hi,
  output logic         sel_lo,
  output logic         editing,
  output logic         commit,
  output logic         abort,
  output logic         drop
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [W-1:0]  HI_TOP    = W'(HI_MAX);
  localparam logic [W-1:0]  LO_TOP    = W'(LO_MAX);
  localparam logic [TW-1:0] TIMER_TOP = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SET_HI, SET_LO, DONE} state_t;

  state_t        state;
  logic          pend_mode, pend_inc, pend_dec;
  logic [W-1:0]  snap_hi, snap_lo;
  logic [TW-1:0] timer;

  logic can_svc;
  logic svc_mode, svc_inc, svc_dec;

  // DONE holds every pending event so that it is handled once the FSM is
  // back in IDLE. In every other state the highest-priority pending flag
  // is serviced.
  always_comb begin
    can_svc  = (state != DONE);
    svc_mode = can_svc & pend_mode;
    svc_inc  = can_svc & pend_inc & ~pend_mode;
    svc_dec  = can_svc & pend_dec & ~pend_mode & ~pend_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend_mode <= 1'b0;
      pend_inc  <= 1'b0;
      pend_dec  <= 1'b0;
      snap_hi   <= '0;
      snap_lo   <= '0;
      timer     <= '0;
      hi_val    <= '0;
      lo_val    <= '0;
      sel_hi    <= 1'b0;
      sel_lo    <= 1'b0;
      editing   <= 1'b0;
      commit    <= 1'b0;
      abort     <= 1'b0;
      drop      <= 1'b0;
    end else begin
      // A pulse that arrives while its own flag is being serviced simply
      // re-arms the flag. A pulse that arrives while its flag is still
      // waiting is lost, and that loss is reported on drop.
      pend_mode <= (pend_mode & ~svc_mode) | mode_pulse;
      pend_inc  <= (pend_inc  & ~svc_inc)  | inc_pulse;
      pend_dec  <= (pend_dec  & ~svc_dec)  | dec_pulse;
      drop      <= (mode_pulse & pend_mode & ~svc_mode) |
                   (inc_pulse  & pend_inc  & ~svc_inc)  |
                   (dec_pulse  & pend_dec  & ~svc_dec);
      commit    <= 1'b0;
      abort     <= 1'b0;

      case (state)
        IDLE: begin
          timer <= '0;
          if (svc_mode) begin
            snap_hi <= hi_val;
            snap_lo <= lo_val;
            state   <= SET_HI;
            sel_hi  <= 1'b1;
            editing <= 1'b1;
          end
        end

        SET_HI, SET_LO: begin
          if (svc_mode || svc_inc || svc_dec) begin
            timer <= '0;
          end

          if (svc_mode) begin
            if (state == SET_HI) begin
              state  <= SET_LO;
              sel_hi <= 1'b0;
              sel_lo <= 1'b1;
            end else begin
              state   <= DONE;
              sel_lo  <= 1'b0;
              editing <= 1'b0;
              commit  <= 1'b1;
            end
          end else if (svc_inc) begin
            if (state == SET_HI) begin
              hi_val <= (hi_val == HI_TOP) ? '0 : hi_val + W'(1);
            end else begin
              lo_val <= (lo_val == LO_TOP) ? '0 : lo_val + W'(1);
            end
          end else if (svc_dec) begin
            if (state == SET_HI) begin
              hi_val <= (hi_val == '0) ? HI_TOP : hi_val - W'(1);
            end else begin
              lo_val <= (lo_val == '0) ? LO_TOP : lo_val - W'(1);
            end
          end else if (timer == TIMER_TOP) begin
            // Idle too long: throw away the edit and restore the snapshot.
            state   <= IDLE;
            hi_val  <= snap_hi;
            lo_val  <= snap_lo;
            sel_hi  <= 1'b0;
            sel_lo  <= 1'b0;
            editing <= 1'b0;
            abort   <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          timer <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
